// File: rtl/cwc_trace_pkg.sv
// rtl/cwc_trace_pkg.sv - shared FSM encoding and depth helper for the trace buffer
//
// Purpose: single home for the capture/readout FSM state encoding and the
// buffer depth derivation so the top and the RAM agree on both.
// Contents:
//   state_t   capture/readout FSM states (IDLE, ARMED, DONE, READ)
//   depth_of  buffer depth for a given address width (2**aw)

package cwc_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/cwc_trace_ram.sv
// rtl/cwc_trace_ram.sv - simple dual-port sample store with registered read
//
// Purpose: trace sample storage, one write port and one registered read port,
// written so synthesis maps it onto block RAM. Contents are never reset.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata holds its value while re=0
//   raddr  in   read address
//   rdata  out  read data, valid one cycle after re

module cwc_trace_ram
  import cwc_trace_pkg::*;
#(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = int'(depth_of(ADDR_WIDTH));

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cwc_trace_buf.sv
// rtl/cwc_trace_buf.sv - logic-analyzer trace buffer with wrap-aware ordered readout
//
// Purpose: captures probe samples while the trigger core holds the capture
// window open, then replays them oldest-first over a valid/ready stream.
// Ports:
//   trig_clk    in   sole clock, rising edge
//   trig_rst    in   asynchronous active-high reset
//   wt_ce       in   capture window active
//   wt_en       in   write strobe
//   wt_addr     in   write address (low ADDR_WIDTH bits used)
//   sample_din  in   probe sample aligned with wt_en
//   rd_start    in   single-cycle readout request
//   rd_ready    in   consumer accepts rd_data
//   rd_valid    out  rd_data valid
//   rd_data     out  readout sample, oldest first
//   rd_last     out  final readout sample
//   cap_done    out  capture finished, buffer readable
//   cap_count   out  valid sample count, saturates at DEPTH
//   wrapped     out  more than DEPTH writes in the current capture

module cwc_trace_buf
  import cwc_trace_pkg::*;
#(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  trig_clk,
  input  logic                  trig_rst,
  input  logic                  wt_ce,
  input  logic                  wt_en,
  input  logic [15:0]           wt_addr,
  input  logic [DATA_WIDTH-1:0] sample_din,
  input  logic                  rd_start,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  cap_done,
  output logic [ADDR_WIDTH:0]   cap_count,
  output logic                  wrapped
);

  localparam int DEPTH = int'(depth_of(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_CNT   = (ADDR_WIDTH+1)'(1);

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] last_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   issue_left;
  logic [DATA_WIDTH-1:0] ram_q;

  logic wr_fire;
  logic arm_entry;
  logic read_entry;
  logic issue;
  logic beat_taken;

  logic unused_addr_bits;
  assign unused_addr_bits = ^wt_addr[15:ADDR_WIDTH];

  assign wr_fire    = (state == ST_ARMED) && wt_ce && wt_en;
  assign beat_taken = rd_valid && rd_ready;
  // A fetch may launch when the output register is empty or being drained
  // this cycle; the RAM output then doubles as the stream data register.
  assign issue      = (state == ST_READ) && (issue_left != '0) && (!rd_valid || rd_ready);
  assign arm_entry  = (state != ST_ARMED) && (state_next == ST_ARMED);
  assign read_entry = (state == ST_DONE) && (state_next == ST_READ);

  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (wt_ce) state_next = ST_ARMED;
      ST_ARMED: if (!wt_ce) state_next = ST_DONE;
      // Re-arm takes priority over a coincident readout request.
      ST_DONE: begin
        if (wt_ce) begin
          state_next = ST_ARMED;
        end else if (rd_start && (cap_count != '0)) begin
          state_next = ST_READ;
        end
      end
      ST_READ:  if (beat_taken && rd_last) state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) begin
      cap_count  <= '0;
      wrapped    <= 1'b0;
      last_addr  <= '0;
      rd_addr    <= '0;
      issue_left <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      if (arm_entry) begin
        cap_count <= '0;
        wrapped   <= 1'b0;
        last_addr <= '0;
      end else if (wr_fire) begin
        last_addr <= wt_addr[ADDR_WIDTH-1:0];
        if (cap_count == DEPTH_CNT) begin
          wrapped <= 1'b1;
        end else begin
          cap_count <= cap_count + ONE_CNT;
        end
      end

      // After a wrap the oldest surviving sample sits just past the last write.
      if (read_entry) begin
        rd_addr    <= wrapped ? last_addr + 1'b1 : '0;
        issue_left <= cap_count;
      end else if (issue) begin
        rd_addr    <= rd_addr + 1'b1;
        issue_left <= issue_left - ONE_CNT;
      end

      if (issue) begin
        rd_valid <= 1'b1;
        rd_last  <= (issue_left == ONE_CNT);
      end else if (beat_taken) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

  cwc_trace_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (trig_clk),
    .we    (wr_fire),
    .waddr (wt_addr[ADDR_WIDTH-1:0]),
    .wdata (sample_din),
    .re    (issue),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // RAM output is not reset, so mask it to keep rd_data at zero when idle.
  assign rd_data  = rd_valid ? ram_q : '0;
  assign cap_done = (state == ST_DONE);

endmodule

// File: doc/cwc_trace_buf.md
CWC_TRACE_BUF -- requirements
Module: cwc_trace_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 7, meaning sample width (probe bus node count).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning log2 of buffer depth; DEPTH = 2^ADDR_WIDTH.
REQ-003 SHALL have port trig_clk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port trig_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wt_ce  input  1  capture window active, from the trigger core.
REQ-006 SHALL have port wt_en  input  1  write strobe, from the trigger core.
REQ-007 SHALL have port wt_addr  input  16  write address; only bits [ADDR_WIDTH-1:0] used.
REQ-008 SHALL have port sample_din  input  DATA_WIDTH  probe sample aligned with wt_en.
REQ-009 SHALL have port rd_start  input  1  single-cycle pulse requesting readout.
REQ-010 SHALL have port rd_ready  input  1  consumer accepts rd_data.
REQ-011 SHALL have port rd_valid  output  1  rd_data valid.
REQ-012 SHALL have port rd_data  output  DATA_WIDTH  readout sample, oldest first.
REQ-013 SHALL have port rd_last  output  1  marks final readout sample.
REQ-014 SHALL have port cap_done  output  1  capture finished, buffer readable.
REQ-015 SHALL have port cap_count  output  ADDR_WIDTH+1  valid sample count, saturates at DEPTH.
REQ-016 SHALL have port wrapped  output  1  more than DEPTH writes in the current capture.

Function
REQ-017 SHALL implement FSM states IDLE, ARMED, DONE, READ.
REQ-018 IDLE->ARMED when wt_ce=1; entry clears cap_count, wrapped, last_addr.
REQ-019 In ARMED, wt_ce=1 and wt_en=1 SHALL write sample_din to mem[wt_addr[ADDR_WIDTH-1:0]] that cycle, latch last_addr, increment cap_count (saturating at DEPTH).
REQ-020 A write while cap_count=DEPTH SHALL set wrapped=1.
REQ-021 wt_en=1 with wt_ce=0, or in DONE/READ, SHALL be ignored (no write, no count change).
REQ-022 ARMED->DONE on the first cycle wt_ce=0; cap_done=1 from the next cycle while in DONE.
REQ-023 DONE->ARMED on wt_ce=1 (re-arm, prior data discarded); wt_ce=1 and rd_start=1 in the same DONE cycle: re-arm wins.
REQ-024 DONE->READ on rd_start=1 when cap_count>0; rd_start with cap_count=0 SHALL be ignored; rd_start outside DONE SHALL be ignored.
REQ-025 READ start address SHALL be (last_addr+1) mod DEPTH if wrapped, else 0; address increments mod DEPTH per accepted beat.
REQ-026 First rd_valid SHALL assert no later than 2 cycles after rd_start; memory read latency is 1 cycle.
REQ-027 rd_data/rd_valid/rd_last SHALL hold stable while rd_valid=1 and rd_ready=0; with rd_ready held high, one beat per cycle.
REQ-028 Exactly cap_count beats SHALL be emitted; rd_last=1 on the final beat only.
REQ-029 Acceptance of the rd_last beat SHALL return the FSM to DONE, contents unchanged (re-readable).
REQ-030 wt_ce=1 during READ SHALL be ignored until READ ends.

Reset
REQ-031 trig_rst=1 SHALL force, asynchronously, state=IDLE, rd_valid=0, rd_last=0, rd_data=0, cap_done=0, cap_count=0, wrapped=0, including mid-capture and mid-readout.
REQ-032 Memory contents SHALL NOT be reset.

Structure
REQ-033 FSM state encoding and the DEPTH derivation SHALL reside in shared package cwc_trace_pkg.
REQ-034 Storage SHALL be a sub-module cwc_trace_ram: simple dual-port, 1 write port, 1 registered read port, inferable as block RAM.

Verification (ADDR_WIDTH=4, DATA_WIDTH=7)
REQ-035 5 writes addr 0..4, data 0x10..0x14, drop wt_ce, pulse rd_start, rd_ready=1 -> 0x10..0x14 in order, rd_last on 0x14, cap_count=5, wrapped=0.
REQ-036 20 writes addr 0..15,0..3, data=index -> wrapped=1, cap_count=16, readout data 4..19 mod 128, starting at addr 4.
REQ-037 Readout with rd_ready toggling 1,0,0,1 -> no beat lost or duplicated; rd_data stable while stalled.
REQ-038 wt_en=1 with wt_ce=0 for 3 cycles, then rd_start with cap_count=0 -> no write, no rd_valid, state DONE/IDLE unchanged.
REQ-039 trig_rst pulsed on the 3rd readout beat -> rd_valid=0 immediately, cap_done=0, state IDLE; new capture then behaves as REQ-035.
REQ-040 wt_ce and rd_start asserted in the same DONE cycle -> re-arm, cap_count=0, no rd_valid.
